mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single RAM port between the instruction-cache refill engine and the data-side (LSU) port.
//  Grants one requester at a time and runs the matching RAM transaction: an ic line-refill burst of
//  BURST_LEN words, or a single-word dc read/write. Returns data and completion pulses to the owner.
//  Sits between the icache controller / LSU and the external RAM interface.
// PARAMETERS
//  ADDR_W     32  byte-address width (matches pc_size)
//  DATA_W     32  RAM word width (matches memory_word); address step per word = DATA_W/8
//  BURST_LEN  4   words per icache line refill; power of two, >=2
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst            in   1       asynchronous, active-high reset
//  ic_req         in   1       icache refill request; held until ic_done
//  ic_addr        in   ADDR_W  refill address; low log2(BURST_LEN*DATA_W/8) bits forced to 0
//  ic_word        out  DATA_W  refill word, valid with ic_word_valid
//  ic_word_valid  out  1       one-cycle pulse per returned refill word
//  ic_done        out  1       one-cycle pulse coincident with the last ic_word_valid
//  dc_req         in   1       data access request; held until dc_ack
//  dc_we          in   1       1 = write, 0 = read; sampled at grant
//  dc_addr        in   ADDR_W  data word address; sampled at grant
//  dc_wdata       in   DATA_W  write data; sampled at grant
//  dc_rdata       out  DATA_W  read data; valid with dc_ack (reads only)
//  dc_ack         out  1       one-cycle completion pulse
//  ram_req        out  1       RAM access request
//  ram_we         out  1       RAM write enable
//  ram_address    out  ADDR_W  RAM byte address
//  ram_wdata      out  DATA_W  RAM write data
//  mem_word       in   DATA_W  RAM read data, valid with word_ready
//  word_ready     in   1       RAM completes the current word this cycle
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  - States: IDLE, IC_BURST, DC_ACCESS, RESP. All outputs registered.
//  - Reset (async assert, any state incl. mid-burst): state=IDLE, word count=0, every output 0,
//    priority pointer=IC-last; an aborted burst produces no ic_done; the owner re-requests after reset.
//  - IDLE: dc_req only -> DC_ACCESS; ic_req only -> IC_BURST; both -> dc wins (see CONFIGURATION).
//    Grant latches address/we/wdata; ram_req/ram_we/ram_address/ram_wdata are valid the next cycle.
//  - IC_BURST: ram_req=1, ram_we=0 throughout. Each word_ready: ic_word<=mem_word, ic_word_valid=1
//    next cycle, count++, ram_address += DATA_W/8 (from the next cycle on). On the BURST_LEN-th
//    word_ready -> RESP, ram_req drops. The address never crosses the aligned line (no wrap).
//  - DC_ACCESS: ram_req=1, ram_we=dc_we. On word_ready: dc_rdata<=mem_word (reads; writes leave it
//    unchanged) -> RESP, ram_req drops.
//  - RESP (1 cycle): pulse dc_ack, or ic_done + the last ic_word_valid; -> IDLE. The requester drops
//    req on the edge ending RESP, so IDLE never re-grants a completed request.
//  - word_ready outside IC_BURST/DC_ACCESS is ignored. A req deasserted mid-transaction is ignored:
//    the transaction completes and pulses done/ack anyway.
//  - Zero-wait latency: req sampled in IDLE at t -> ram_req at t+1 -> dc_ack at t+2; IC words at
//    t+2..t+BURST_LEN+1, with ic_done at t+BURST_LEN+1. Minimum 1 IDLE cycle between transactions.
//  - Word count is log2(BURST_LEN) bits; it is cleared at grant and at reset.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: a 1-bit last-served pointer (reset = IC-served) is updated at each
//    grant. On simultaneous requests the requester not served last wins, so back-to-back contention
//    alternates DC, IC, DC, ...
//  Not defined: fixed priority, dc_req always wins over ic_req. No pointer flop.
// TESTING
//  1 Reset: assert rst mid-IC_BURST at word 2 -> all outputs 0 at once, no ic_done; re-request completes normally.
//  2 IC refill, ic_addr=0x104, BURST_LEN=4, word_ready every cycle -> ram_address 0x100,0x104,0x108,0x10C;
//    4 ic_word_valid pulses; ic_done with the 4th word.
//  3 DC read dc_addr=0x2000, word_ready after 3 wait cycles, mem_word=0xDEADBEEF -> ram_we=0,
//    dc_ack one cycle after word_ready, dc_rdata=0xDEADBEEF.
//  4 DC write 0x2004/0x12345678 -> ram_we=1, ram_wdata=0x12345678 held until word_ready; dc_ack; ic idle.
//  5 ic_req and dc_req both high in IDLE, repeated 4x -> fixed: DC,DC,DC,DC while dc holds;
//    MEM_ARB_ROUND_ROBIN_EN: DC,IC,DC,IC.
//  6 dc_req raised during an IC burst -> burst completes uninterrupted; DC granted in the next IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single RAM port between icache line refills and single-word LSU accesses.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed DC priority.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_word,
   output logic              ic_word_valid,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_ack,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] mem_word,
   input  logic              word_ready,
   output logic              busy
);

   localparam int CNT_W = $clog2(BURST_LEN);
   localparam int STEP  = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN * STEP - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, IC_BURST, DC_ACCESS, RESP} state_t;

   state_t            r_state, w_state;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic              r_ram_req, w_ram_req;
   logic              r_ram_we, w_ram_we;
   logic [ADDR_W-1:0] r_ram_address, w_ram_address;
   logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata;
   logic [DATA_W-1:0] r_ic_word, w_ic_word;
   logic              r_ic_word_valid, w_ic_word_valid;
   logic              r_ic_done, w_ic_done;
   logic [DATA_W-1:0] r_dc_rdata, w_dc_rdata;
   logic              r_dc_ack, w_dc_ack;
   logic              r_busy, w_busy;
   logic              w_grant_dc;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic              r_last_ic, w_last_ic;

   // On contention DC wins only if IC was the last one served
   assign w_grant_dc = dc_req && (!ic_req || r_last_ic);
`else
   assign w_grant_dc = dc_req;
`endif

   always_comb begin
      w_state         = r_state;
      w_cnt           = r_cnt;
      w_ram_req       = r_ram_req;
      w_ram_we        = r_ram_we;
      w_ram_address   = r_ram_address;
      w_ram_wdata     = r_ram_wdata;
      w_ic_word       = r_ic_word;
      w_ic_word_valid = 1'b0;
      w_ic_done       = 1'b0;
      w_dc_rdata      = r_dc_rdata;
      w_dc_ack        = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w_last_ic       = r_last_ic;
`endif
      case (r_state)
         IDLE: begin
            if (w_grant_dc) begin
               w_state       = DC_ACCESS;
               w_cnt         = '0;
               w_ram_req     = 1'b1;
               w_ram_we      = dc_we;
               w_ram_address = dc_addr;
               w_ram_wdata   = dc_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               w_last_ic     = 1'b0;
`endif
            end else if (ic_req) begin
               w_state       = IC_BURST;
               w_cnt         = '0;
               w_ram_req     = 1'b1;
               w_ram_we      = 1'b0;
               w_ram_address = ic_addr & LINE_MASK;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               w_last_ic     = 1'b1;
`endif
            end
         end
         IC_BURST: begin
            if (word_ready) begin
               w_ic_word       = mem_word;
               w_ic_word_valid = 1'b1;
               // Last beat: address stays on the final word so it never leaves the line
               if (r_cnt == LAST_CNT) begin
                  w_state   = RESP;
                  w_ram_req = 1'b0;
                  w_ic_done = 1'b1;
               end else begin
                  w_cnt         = r_cnt + 1'b1;
                  w_ram_address = r_ram_address + ADDR_W'(STEP);
               end
            end
         end
         DC_ACCESS: begin
            if (word_ready) begin
               if (!r_ram_we) begin
                  w_dc_rdata = mem_word;
               end
               w_dc_ack  = 1'b1;
               w_state   = RESP;
               w_ram_req = 1'b0;
               w_ram_we  = 1'b0;
            end
         end
         RESP: begin
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase
      w_busy = (w_state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= IDLE;
         r_cnt           <= '0;
         r_ram_req       <= 1'b0;
         r_ram_we        <= 1'b0;
         r_ram_address   <= '0;
         r_ram_wdata     <= '0;
         r_ic_word       <= '0;
         r_ic_word_valid <= 1'b0;
         r_ic_done       <= 1'b0;
         r_dc_rdata      <= '0;
         r_dc_ack        <= 1'b0;
         r_busy          <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         r_last_ic       <= 1'b1;
`endif
      end else begin
         r_state         <= w_state;
         r_cnt           <= w_cnt;
         r_ram_req       <= w_ram_req;
         r_ram_we        <= w_ram_we;
         r_ram_address   <= w_ram_address;
         r_ram_wdata     <= w_ram_wdata;
         r_ic_word       <= w_ic_word;
         r_ic_word_valid <= w_ic_word_valid;
         r_ic_done       <= w_ic_done;
         r_dc_rdata      <= w_dc_rdata;
         r_dc_ack        <= w_dc_ack;
         r_busy          <= w_busy;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         r_last_ic       <= w_last_ic;
`endif
      end
   end

   assign ic_word       = r_ic_word;
   assign ic_word_valid = r_ic_word_valid;
   assign ic_done       = r_ic_done;
   assign dc_rdata      = r_dc_rdata;
   assign dc_ack        = r_dc_ack;
   assign ram_req       = r_ram_req;
   assign ram_we        = r_ram_we;
   assign ram_address   = r_ram_address;
   assign ram_wdata     = r_ram_wdata;
   assign busy          = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked against
// transaction-level expectations (line base, beat data, winner choice, read-data history).
module tb_mem_port_arbiter;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int BURST_LEN = 4;
   localparam int STEP      = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic [DATA_W-1:0] ic_word;
   logic              ic_word_valid;
   logic              ic_done;
   logic              dc_req;
   logic              dc_we;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_wdata;
   logic [DATA_W-1:0] dc_rdata;
   logic              dc_ack;
   logic              ram_req;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] mem_word;
   logic              word_ready;
   logic              busy;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   logic [DATA_W-1:0] exp_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   bit last_ic;
`endif

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_word(ic_word),
      .ic_word_valid(ic_word_valid), .ic_done(ic_done),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_rdata(dc_rdata), .dc_ack(dc_ack),
      .ram_req(ram_req), .ram_we(ram_we), .ram_address(ram_address), .ram_wdata(ram_wdata),
      .mem_word(mem_word), .word_ready(word_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, {ic_word, dc_rdata}, 64'd0);
      chk({tag, "_ctl"}, {ic_word_valid, ic_done, dc_ack, ram_req, ram_we, busy}, 64'd0);
      chk({tag, "_ram"}, {ram_address, ram_wdata}, 64'd0);
   endtask

   // Winner for the requests currently presented: DC alone, IC alone, or contention rule.
   function automatic bit pick_dc();
      if (dc_req && !ic_req) return 1'b1;
      if (ic_req && !dc_req) return 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return last_ic;
`else
      return 1'b1;
`endif
   endfunction

   // Called right after the grant edge of a DC access.
   task automatic run_dc(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] rd, input int waits);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_ic = 1'b0;
`endif
      chk("dc_grant", {ram_req, ram_we, ram_address}, {1'b1, we, a});
      if (we) chk("dc_grant_wdata", ram_wdata, wd);
      chk("dc_grant_busy", {busy, dc_ack}, 2'b10);
      dc_we    = 1'($urandom);
      dc_addr  = $urandom;
      dc_wdata = $urandom;
      for (int i = 0; i < waits; i++) begin
         word_ready = 1'b0;
         mem_word   = $urandom;
         step();
         chk("dc_wait_hold", {ram_req, ram_we, ram_address, dc_ack}, {1'b1, we, a, 1'b0});
         if (we) chk("dc_wait_wdata", ram_wdata, wd);
      end
      word_ready = 1'b1;
      mem_word   = rd;
      step();
      if (!we) exp_rdata = rd;
      chk("dc_ack", dc_ack, 1'b1);
      chk("dc_rdata", dc_rdata, exp_rdata);
      chk("dc_resp_ram", {ram_req, ic_word_valid, ic_done, busy}, 4'b0001);
      dc_req     = 1'b0;
      word_ready = 1'($urandom);
      mem_word   = $urandom;
      step();
      chk("dc_idle", {dc_ack, busy, ram_req}, 3'b000);
   endtask

   // Called right after the grant edge of an IC refill.
   task automatic run_ic(input logic [ADDR_W-1:0] a, input int max_wait, input bit raise_dc);
      logic [ADDR_W-1:0] base;
      logic [DATA_W-1:0] d;
      base = a & ~ADDR_W'(BURST_LEN * STEP - 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_ic = 1'b1;
`endif
      chk("ic_grant", {ram_req, ram_we, ram_address}, {1'b1, 1'b0, base});
      chk("ic_grant_flags", {ic_word_valid, ic_done, busy}, 3'b001);
      ic_addr = $urandom;
      for (int k = 0; k < BURST_LEN; k++) begin
         if (raise_dc && k == 1) dc_req = 1'b1;
         repeat ($urandom_range(0, max_wait)) begin
            word_ready = 1'b0;
            mem_word   = $urandom;
            step();
            chk("ic_wait", {ram_req, ram_we, ram_address, ic_word_valid, ic_done, dc_ack},
                {1'b1, 1'b0, base + ADDR_W'(STEP * k), 3'b000});
         end
         d          = $urandom;
         word_ready = 1'b1;
         mem_word   = d;
         step();
         chk("ic_word_valid", ic_word_valid, 1'b1);
         chk("ic_word", ic_word, d);
         chk("ic_done", ic_done, (k == BURST_LEN - 1));
         if (k < BURST_LEN - 1)
            chk("ic_next_addr", {ram_req, ram_we, ram_address, dc_ack},
                {1'b1, 1'b0, base + ADDR_W'(STEP * (k + 1)), 1'b0});
         else
            chk("ic_end_ram", {ram_req, dc_ack, busy}, 3'b001);
      end
      ic_req     = 1'b0;
      word_ready = 1'($urandom);
      mem_word   = $urandom;
      step();
      chk("ic_idle", {ic_word_valid, ic_done, busy, ram_req}, 4'b0000);
   endtask

   // Grant edge plus completion of whichever requester the model says wins.
   task automatic serve();
      bit is_dc;
      is_dc = pick_dc();
      step();
      if (is_dc) run_dc(dc_we, dc_addr, dc_wdata, $urandom, $urandom_range(0, 3));
      else       run_ic(ic_addr, 2, 1'b0);
   endtask

   bit exp_seq [4];

   initial begin
      rst = 1'b1; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
      dc_addr = '0; dc_wdata = '0; mem_word = '0; word_ready = 1'b0;
      exp_rdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_ic = 1'b1;
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      #12;
      chk_all_zero("reset");
      step();
      rst = 1'b0;

      // Aligned line refill, zero wait states
      ic_addr = 32'h104; ic_req = 1'b1;
      step();
      run_ic(32'h104, 0, 1'b0);

      // DC read with three wait cycles
      dc_we = 1'b0; dc_addr = 32'h2000; dc_req = 1'b1;
      step();
      run_dc(1'b0, 32'h2000, 32'h0, 32'hDEADBEEF, 3);

      // DC write: rdata must keep the previous read value
      dc_we = 1'b1; dc_addr = 32'h2004; dc_wdata = 32'h12345678; dc_req = 1'b1;
      step();
      run_dc(1'b1, 32'h2004, 32'h12345678, $urandom, 2);

      // DC arrives mid-burst: burst finishes, DC served in the following idle
      ic_addr = 32'h1234; ic_req = 1'b1;
      dc_we = 1'b0; dc_addr = 32'h2008;
      step();
      run_ic(32'h1234, 1, 1'b1);
      step();
      run_dc(1'b0, 32'h2008, 32'h0, $urandom, 1);

      // Make IC the last served, then contend four times
      ic_addr = 32'h3000; ic_req = 1'b1;
      step();
      run_ic(32'h3000, 1, 1'b0);
      ic_addr = 32'h1040; ic_req = 1'b1;
      dc_we = 1'b0; dc_addr = 32'h2010; dc_req = 1'b1;
      for (int r = 0; r < 4; r++) begin
         bit is_dc;
         logic [ADDR_W-1:0] cur_dc;
         cur_dc = dc_addr;
         is_dc  = pick_dc();
         step();
         chk("arb_order", ram_address, exp_seq[r] ? cur_dc : 32'h1040);
         if (is_dc) begin
            run_dc(1'b0, cur_dc, 32'h0, $urandom, $urandom_range(0, 2));
            dc_we = 1'b0; dc_addr = cur_dc + 32'd4; dc_req = 1'b1;
         end else begin
            run_ic(32'h1040, 1, 1'b0);
            ic_addr = 32'h1040; ic_req = 1'b1;
         end
      end
      serve();
      serve();

      // Reset asserted mid-burst after the second word
      ic_addr = 32'h5008; ic_req = 1'b1;
      step();
      word_ready = 1'b1;
      mem_word = $urandom;
      step();
      mem_word = $urandom;
      step();
      chk("pre_rst_word2", {ic_word_valid, ic_done, ram_address}, {2'b10, 32'h5008});
      #2 rst = 1'b1;
      #1 chk_all_zero("rst_async");
      word_ready = 1'b0;
      step();
      chk_all_zero("rst_held");
      rst = 1'b0;
      exp_rdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_ic = 1'b1;
`endif
      step();
      run_ic(32'h5008, 1, 1'b0);

      // Randomized traffic: IC alone, DC alone, or both
      for (int t = 0; t < 24; t++) begin
         int kind;
         kind = $urandom_range(0, 2);
         if (kind != 1) begin
            ic_addr = $urandom;
            ic_req  = 1'b1;
         end
         if (kind != 0) begin
            dc_we    = 1'($urandom);
            dc_addr  = $urandom & 32'hFFFF_FFFC;
            dc_wdata = $urandom;
            dc_req   = 1'b1;
         end
         serve();
         if (kind == 2) serve();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
